mbru_prefetch_buffer: RTL and testbench

- Parametrised successor to the single-register memory buffer unit.
- A small in-order instruction buffer that sits between the IRAM output and the control store. It accepts instructions on a valid/ready push handshake and presents the oldest one to the control store with a valid flag.
- The control store consumes with a pop strobe. While empty, the last consumed instruction stays on ins_out, matching the legacy hold semantics. A synchronous flush discards buffered instructions on jumps and branches.

---
 rtl/mbru_pkg.sv | 22 ++
 rtl/mbru_buf_mem.sv | 27 ++
 rtl/mbru_prefetch_buffer.sv | 93 +++++++++
 tb/tb_mbru_prefetch_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mbru_pkg.sv
// Shared definitions for the memory buffer unit family.
package mbru_pkg;

    // Default instruction width.
    localparam int unsigned DEF_INS_W = 8;

    // Value shown on ins_out after reset, before anything has been consumed.
    localparam logic [DEF_INS_W-1:0] NOP_INS = '0;

    // Bits needed to hold an occupancy count in the range 0..depth.
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < (64'(depth) + 64'd1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mbru_buf_mem.sv
// Storage for the prefetch buffer: synchronous write, asynchronous read.
module mbru_buf_mem #(
    parameter int unsigned INS_W  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INS_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INS_W-1:0]  rdata
);

    logic [INS_W-1:0] mem [DEPTH];

    // Write port; the array is not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port.
    assign rdata = mem[raddr];

endmodule

// File: rtl/mbru_prefetch_buffer.sv
// In-order instruction buffer between the IRAM output and the control store.
// When empty, ins_out keeps showing the most recently consumed instruction.
module mbru_prefetch_buffer
    import mbru_pkg::*;
#(
    parameter int unsigned INS_W = DEF_INS_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = clog2_cnt(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [INS_W-1:0] ins_in,
    input  logic             pop,
    output logic             out_valid,
    output logic [INS_W-1:0] ins_out,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [INS_W-1:0] hold_q;
    logic [INS_W-1:0] rd_data_c;
    logic             push_acc_c;
    logic             pop_acc_c;
    logic [CNT_W-1:0] count_nxt_c;

    mbru_buf_mem #(
        .INS_W (INS_W),
        .DEPTH (DEPTH),
        .ADDR_W(PTR_W)
    ) u_mem (
        .clk  (clk),
        .we   (push_acc_c),
        .waddr(wr_ptr),
        .wdata(ins_in),
        .raddr(rd_ptr),
        .rdata(rd_data_c)
    );

    // Accept decisions and next occupancy; flush overrides both handshakes.
    always_comb begin
        push_acc_c  = push_valid && push_ready && !flush;
        pop_acc_c   = pop && out_valid && !flush;
        count_nxt_c = count;
        if (flush) begin
            count_nxt_c = '0;
        end else if (push_acc_c && !pop_acc_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (pop_acc_c && !push_acc_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    // Pointers, occupancy, status flags and the consumed-value hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            push_ready <= 1'b1;
            hold_q     <= INS_W'(NOP_INS);
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_acc_c) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_acc_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (pop_acc_c) begin
                hold_q <= rd_data_c;
            end
            count      <= count_nxt_c;
            out_valid  <= (count_nxt_c != '0);
            push_ready <= (count_nxt_c != FULL_CNT);
        end
    end

    // Head entry while occupied, otherwise the last consumed instruction.
    assign ins_out = out_valid ? rd_data_c : hold_q;

endmodule

// File: tb/tb_mbru_prefetch_buffer.sv
// Bench for mbru_prefetch_buffer: a 4x8 and an 8x16 instance share one
// stimulus stream and are compared every cycle against queue-based models.
module tb_mbru_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        push_valid;
    logic        pop;
    logic [15:0] ins_in;

    logic        pr_a, ov_a;
    logic [7:0]  io_a;
    logic [2:0]  cnt_a;
    logic        pr_b, ov_b;
    logic [15:0] io_b;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference model: one queue plus last-consumed value per instance.
    logic [15:0] mq [2][$];
    logic [15:0] mhold [2];
    int          mdepth [2];

    always #5 clk = ~clk;

    mbru_prefetch_buffer #(.INS_W(8), .DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid),
        .push_ready(pr_a), .ins_in(ins_in[7:0]), .pop(pop),
        .out_valid(ov_a), .ins_out(io_a), .count(cnt_a)
    );

    mbru_prefetch_buffer #(.INS_W(16), .DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .push_valid(push_valid),
        .push_ready(pr_b), .ins_in(ins_in), .pop(pop),
        .out_valid(ov_b), .ins_out(io_b), .count(cnt_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the model: full/empty judged on the occupancy before the edge.
    task automatic model_tick();
        for (int i = 0; i < 2; i++) begin
            int n;
            logic [15:0] d;
            n = mq[i].size();
            d = (i == 0) ? {8'h00, ins_in[7:0]} : ins_in;
            if (flush) begin
                mq[i].delete();
            end else begin
                if (pop && n > 0) begin
                    mhold[i] = mq[i].pop_front();
                end
                if (push_valid && n < mdepth[i]) begin
                    mq[i].push_back(d);
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mhold[i] = '0;
        end
    endtask

    // Model follows the DUT clock and its asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_tick();
    end

    function automatic int exp_out(input int i);
        return (mq[i].size() > 0) ? int'(mq[i][0]) : int'(mhold[i]);
    endfunction

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_on && rst_n === 1'b1) begin
            check("a_count", int'(cnt_a), mq[0].size());
            check("a_valid", int'(ov_a), int'(mq[0].size() != 0));
            check("a_ready", int'(pr_a), int'(mq[0].size() < mdepth[0]));
            check("a_ins",   int'(io_a), exp_out(0));
            check("b_count", int'(cnt_b), mq[1].size());
            check("b_valid", int'(ov_b), int'(mq[1].size() != 0));
            check("b_ready", int'(pr_b), int'(mq[1].size() < mdepth[1]));
            check("b_ins",   int'(io_b), exp_out(1));
        end
    end

    // Drive one cycle of inputs, then return them to idle just after the edge.
    task automatic step(input bit pv, input logic [15:0] d, input bit p, input bit f);
        push_valid = pv;
        ins_in     = d;
        pop        = p;
        flush      = f;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        logic [7:0] drain_exp [4];
        drain_exp = '{8'h22, 8'h33, 8'h44, 8'h44};
        mdepth[0] = 4;
        mdepth[1] = 8;
        rst_n = 1'b0;
        flush = 1'b0; push_valid = 1'b0; pop = 1'b0; ins_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_count", int'(cnt_a), 0);
        check("rst_valid", int'(ov_a), 0);
        check("rst_ready", int'(pr_a), 1);
        check("rst_ins",   int'(io_a), 0);
        chk_on = 1'b1;

        // Fill to full, then try a push while full.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'(8'h11 * (k + 1)), 1'b0, 1'b0);
            check("fill_count", int'(cnt_a), k + 1);
        end
        check("full_ready", int'(pr_a), 0);
        check("full_ins",   int'(io_a), 'h11);
        check("full_valid", int'(ov_a), 1);
        step(1'b1, 16'h0055, 1'b0, 1'b0);
        check("over_count", int'(cnt_a), 4);
        check("over_ins",   int'(io_a), 'h11);

        // Drain and hold the last consumed value; an extra pop does nothing.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            check("drain_ins", int'(io_a), int'(drain_exp[k]));
        end
        check("drain_valid", int'(ov_a), 0);
        check("drain_count", int'(cnt_a), 0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("xpop_count", int'(cnt_a), 0);
        check("xpop_ins",   int'(io_a), 'h44);

        // Simultaneous push and pop at count 2.
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h00A1, 1'b0, 1'b0);
        step(1'b1, 16'h00A2, 1'b0, 1'b0);
        check("pp_pre_count", int'(cnt_a), 2);
        step(1'b1, 16'h00A3, 1'b1, 1'b0);
        check("pp_count", int'(cnt_a), 2);
        check("pp_ins",   int'(io_a), 'hA2);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("pp_pop1_ins", int'(io_a), 'hA3);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("pp_pop2_count", int'(cnt_a), 0);
        check("pp_pop2_ins",   int'(io_a), 'hA3);

        // Pointers wrap several times with single-entry traffic.
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 16'(k), 1'b0, 1'b0);
            check("wrap_push_ins",   int'(io_a), k);
            check("wrap_push_count", int'(cnt_a), 1);
            step(1'b0, 16'h0000, 1'b1, 1'b0);
            check("wrap_pop_ins",   int'(io_a), k);
            check("wrap_pop_count", int'(cnt_a), 0);
        end

        // Flush beats a concurrent push and pop and keeps the held value.
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h009F, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 16'h00B1, 1'b0, 1'b0);
        step(1'b1, 16'h00B2, 1'b0, 1'b0);
        step(1'b1, 16'h00B3, 1'b0, 1'b0);
        check("fl_pre_count", int'(cnt_a), 3);
        step(1'b1, 16'h00C0, 1'b1, 1'b1);
        check("fl_count", int'(cnt_a), 0);
        check("fl_valid", int'(ov_a), 0);
        check("fl_ins",   int'(io_a), 'h9F);
        check("fl_ins_b", int'(io_b), 'h9F);
        check("fl_ready", int'(pr_a), 1);

        // Random traffic in push-heavy and pop-heavy phases.
        for (int ph = 0; ph < 6; ph++) begin
            int pp;
            int pq;
            pp = (ph % 2 == 0) ? 80 : 30;
            pq = (ph % 2 == 0) ? 30 : 80;
            repeat (400) begin
                step($urandom_range(0, 99) < pp, 16'($urandom),
                     $urandom_range(0, 99) < pq, $urandom_range(0, 99) < 3);
            end
        end

        // Asynchronous reset between clock edges.
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h00D1, 1'b0, 1'b0);
        step(1'b1, 16'h00D2, 1'b0, 1'b0);
        check("ar_pre_count", int'(cnt_a), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count", int'(cnt_a), 0);
        check("ar_ins",   int'(io_a), 0);
        check("ar_ready", int'(pr_a), 1);
        check("ar_valid", int'(ov_a), 0);
        check("ar_count_b", int'(cnt_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h0077, 1'b0, 1'b0);
        check("ar_after_ins", int'(io_a), 'h77);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
